// File: rtl/mux_n_pipe_pkg.sv
// Shared constants and helpers for the selectable-input pipeline.
// Holds legal parameter ranges and the select-width derivation.
package mux_n_pipe_pkg;

    localparam int LENGTH_MIN = 1;
    localparam int LENGTH_MAX = 64;
    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 16;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux_n_pipe_stage_reg.sv
// One pipeline register slice: {valid, data}, with hold and clear.
// Reset and clear both zero the slice; clear beats hold.
module pipe_stage_reg #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clear)
            q <= '0;
        else if (!hold)
            q <= d;
    end

endmodule

// File: rtl/mux_n_pipe.sv
// N-way data select feeding a STAGES-deep register pipeline with
// stall/flush control and a sticky out-of-range select flag.
module mux_n_pipe
    import mux_n_pipe_pkg::*;
#(
    parameter int LENGTH = 8,
    parameter int NUM_IN = 3,
    parameter int STAGES = 1,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*LENGTH-1:0] in_bus,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic [LENGTH-1:0]        out,
    output logic                     out_valid,
    output logic                     sel_err
);

    localparam bit              POW2     = is_pow2(NUM_IN);
    localparam logic [SEL_W:0]  NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    if (LENGTH < LENGTH_MIN || LENGTH > LENGTH_MAX ||
        NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX ||
        STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_param
        $error("mux_n_pipe: parameter out of legal range");
    end

    logic [LENGTH-1:0]        mux_dat;
    logic                     sel_oob;
    logic                     err_set;
    logic [STAGES:0][LENGTH:0] stg;   // bit LENGTH of each slice is its valid

    // Out-of-range select falls back to input 0.
    always_comb begin
        mux_dat = in_bus[0 +: LENGTH];
        for (int k = 1; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k))
                mux_dat = in_bus[k*LENGTH +: LENGTH];
        end
    end

    assign sel_oob = POW2 ? 1'b0 : ({1'b0, sel} >= NUM_IN_W);
    assign err_set = !stall && !flush && in_valid && sel_oob;
    assign stg[0]  = {in_valid, mux_dat};

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        pipe_stage_reg #(.W(LENGTH + 1)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .hold  (stall),
            .clear (flush),
            .d     (stg[k-1]),
            .q     (stg[k])
        );
    end

    // Set wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst)
            sel_err <= 1'b0;
        else if (err_set)
            sel_err <= 1'b1;
        else if (err_clr)
            sel_err <= 1'b0;
    end

    assign out       = stg[STAGES][LENGTH-1:0];
    assign out_valid = stg[STAGES][LENGTH];

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench: three configurations (3-in/1-stage, 3-in/3-stage,
// 4-in/32-bit/2-stage) driven side by side from one clock.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // dut_a: LENGTH=8 NUM_IN=3 STAGES=1
    logic        rst_a, inv_a, stall_a, flush_a, clr_a;
    logic [23:0] bus_a;
    logic [1:0]  sel_a;
    logic [7:0]  out_a;
    logic        ov_a, err_a;

    // dut_b: LENGTH=8 NUM_IN=3 STAGES=3
    logic        rst_b, inv_b, stall_b, flush_b, clr_b;
    logic [23:0] bus_b;
    logic [1:0]  sel_b;
    logic [7:0]  out_b;
    logic        ov_b, err_b;

    // dut_c: LENGTH=32 NUM_IN=4 STAGES=2
    logic         rst_c, inv_c, stall_c, flush_c, clr_c;
    logic [127:0] bus_c;
    logic [1:0]   sel_c;
    logic [31:0]  out_c;
    logic         ov_c, err_c;

    mux_n_pipe #(.LENGTH(8), .NUM_IN(3), .STAGES(1)) dut_a (
        .clk(clk), .rst(rst_a), .in_bus(bus_a), .sel(sel_a), .in_valid(inv_a),
        .stall(stall_a), .flush(flush_a), .err_clr(clr_a),
        .out(out_a), .out_valid(ov_a), .sel_err(err_a)
    );

    mux_n_pipe #(.LENGTH(8), .NUM_IN(3), .STAGES(3)) dut_b (
        .clk(clk), .rst(rst_b), .in_bus(bus_b), .sel(sel_b), .in_valid(inv_b),
        .stall(stall_b), .flush(flush_b), .err_clr(clr_b),
        .out(out_b), .out_valid(ov_b), .sel_err(err_b)
    );

    mux_n_pipe #(.LENGTH(32), .NUM_IN(4), .STAGES(2)) dut_c (
        .clk(clk), .rst(rst_c), .in_bus(bus_c), .sel(sel_c), .in_valid(inv_c),
        .stall(stall_c), .flush(flush_c), .err_clr(clr_c),
        .out(out_c), .out_valid(ov_c), .sel_err(err_c)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1; inv_a = 1; stall_a = 0; flush_a = 0; clr_a = 0; bus_a = 24'h332211; sel_a = 2;
        rst_b = 1; inv_b = 1; stall_b = 0; flush_b = 0; clr_b = 0; bus_b = 24'h332211; sel_b = 1;
        rst_c = 1; inv_c = 1; stall_c = 0; flush_c = 0; clr_c = 0; bus_c = '1;          sel_c = 3;
        step(); step(); step(); step();
        tests++; if ({out_a, ov_a, err_a} !== 10'b0) begin fails++; $display("FAIL reset_a: got %h/%b/%b exp 00/0/0", out_a, ov_a, err_a); end
        tests++; if ({out_b, ov_b, err_b} !== 10'b0) begin fails++; $display("FAIL reset_b: got %h/%b/%b exp 00/0/0", out_b, ov_b, err_b); end
        tests++; if ({out_c, ov_c, err_c} !== 34'b0) begin fails++; $display("FAIL reset_c: got %h/%b/%b exp 0/0/0", out_c, ov_c, err_c); end
        rst_a = 0; rst_b = 0; rst_c = 0;
        inv_a = 0; inv_b = 0; inv_c = 0;
    endtask

    task automatic test_select();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        bus_a = 24'h332211;
        for (int s = 2; s >= 0; s--) begin
            sel_a = 2'(s); inv_a = 1;
            step();
            tests++;
            if (out_a !== exp_d[s] || ov_a !== 1'b1) begin
                fails++; $display("FAIL select_sel%0d: got %h/%b exp %h/1", s, out_a, ov_a, exp_d[s]);
            end
        end
        // Invalid operand: data still moves, valid does not.
        sel_a = 1; inv_a = 0;
        step();
        tests++;
        if (out_a !== 8'h22 || ov_a !== 1'b0) begin
            fails++; $display("FAIL select_invalid: got %h/%b exp 22/0", out_a, ov_a);
        end
    endtask

    task automatic test_sel_err();
        sel_a = 3; inv_a = 1;
        step();
        tests++;
        if (out_a !== 8'h11 || ov_a !== 1'b1 || err_a !== 1'b1) begin
            fails++; $display("FAIL sel_oob: got %h/%b err %b exp 11/1 err 1", out_a, ov_a, err_a);
        end
        sel_a = 0; inv_a = 0;
        step();
        tests++; if (err_a !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b exp 1", err_a); end
        clr_a = 1;
        step();
        clr_a = 0;
        tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL err_clear: got %b exp 0", err_a); end
        clr_a = 1; sel_a = 3; inv_a = 1;
        step();
        clr_a = 0;
        tests++; if (err_a !== 1'b1) begin fails++; $display("FAIL err_set_wins: got %b exp 1", err_a); end
        clr_a = 1; inv_a = 0;
        step();
        clr_a = 0;
        // Stalled and flushed cycles must not set the flag.
        sel_a = 3; inv_a = 1; stall_a = 1;
        step();
        tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL err_stall: got %b exp 0", err_a); end
        stall_a = 0; flush_a = 1;
        step();
        tests++; if (err_a !== 1'b0 || ov_a !== 1'b0) begin fails++; $display("FAIL err_flush: got err %b ov %b exp 0/0", err_a, ov_a); end
        flush_a = 0; inv_a = 0; sel_a = 0;
        step();
    endtask

    task automatic test_stall();
        logic [7:0] exp_o [11];
        logic       exp_v [11];
        for (int i = 1; i <= 10; i++) begin exp_v[i] = 0; exp_o[i] = 0; end
        exp_v[5] = 1; exp_o[5] = 8'h11;
        exp_v[6] = 1; exp_o[6] = 8'h22;
        exp_v[7] = 1; exp_o[7] = 8'h33;
        bus_b = 24'h332211;
        for (int i = 1; i <= 10; i++) begin
            case (i)
                1:       begin sel_b = 0; inv_b = 1; stall_b = 0; end
                2:       begin sel_b = 1; inv_b = 1; stall_b = 0; end
                3, 4:    begin sel_b = 2; inv_b = 1; stall_b = 1; end
                5:       begin sel_b = 2; inv_b = 1; stall_b = 0; end
                default: begin sel_b = 0; inv_b = 0; stall_b = 0; end
            endcase
            step();
            tests++;
            if (ov_b !== exp_v[i] || (exp_v[i] && out_b !== exp_o[i])) begin
                fails++; $display("FAIL stall_cyc%0d: got %h/%b exp %h/%b", i, out_b, ov_b, exp_o[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_flush();
        bus_b = 24'h332211;
        for (int s = 0; s < 3; s++) begin
            sel_b = 2'(s); inv_b = 1;
            step();
        end
        tests++; if (out_b !== 8'h11 || ov_b !== 1'b1) begin fails++; $display("FAIL flush_pre: got %h/%b exp 11/1", out_b, ov_b); end
        sel_b = 0; flush_b = 1; stall_b = 1;
        step();
        flush_b = 0; stall_b = 0; inv_b = 0;
        tests++; if (out_b !== 8'h00 || ov_b !== 1'b0) begin fails++; $display("FAIL flush_now: got %h/%b exp 00/0", out_b, ov_b); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (ov_b !== 1'b0) begin fails++; $display("FAIL flush_after%0d: got ov %b exp 0", i, ov_b); end
        end
    endtask

    task automatic test_reset_mid();
        bus_b = 24'h332211;
        sel_b = 3; inv_b = 1;
        step();
        sel_b = 1;
        step();
        tests++; if (err_b !== 1'b1) begin fails++; $display("FAIL rstmid_err_pre: got %b exp 1", err_b); end
        rst_b = 1; inv_b = 0; sel_b = 0;
        step();
        rst_b = 0;
        tests++; if ({out_b, ov_b, err_b} !== 10'b0) begin fails++; $display("FAIL rstmid_now: got %h/%b/%b exp 00/0/0", out_b, ov_b, err_b); end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (ov_b !== 1'b0) begin fails++; $display("FAIL rstmid_after%0d: got ov %b exp 0", i, ov_b); end
        end
        sel_b = 2; inv_b = 1;
        step();
        inv_b = 0;
        step(); step();
        tests++; if (out_b !== 8'h33 || ov_b !== 1'b1) begin fails++; $display("FAIL rstmid_new: got %h/%b exp 33/1", out_b, ov_b); end
    endtask

    task automatic test_sweep();
        logic [31:0] d [4];
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) d[k] = $urandom();
            bus_c = {d[3], d[2], d[1], d[0]};
            sel_c = 2'(s); inv_c = 1;
            step();
            inv_c = 0; bus_c = '0;
            step();
            tests++;
            if (out_c !== d[s] || ov_c !== 1'b1 || err_c !== 1'b0) begin
                fails++; $display("FAIL sweep_sel%0d: got %h/%b err %b exp %h/1 err 0", s, out_c, ov_c, err_c, d[s]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_sel_err();
        test_stall();
        test_flush();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_n_pipe.md
MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 Parameter LENGTH, default 8: data width in bits of each input and of the output; legal range 1..64.
REQ-002 Parameter NUM_IN, default 3: number of selectable inputs; legal range 2..16.
REQ-003 Parameter STAGES, default 1: register stages between select and output; legal range 1..4.
REQ-004 Derived constant SEL_W = ceil(log2(NUM_IN)): select width in bits.
REQ-005 clk  input  1  Single clock; all state changes on the rising edge.
REQ-006 rst  input  1  Synchronous, active-high reset.
REQ-007 in_bus  input  NUM_IN*LENGTH  Packed inputs; input k occupies bits [k*LENGTH +: LENGTH].
REQ-008 sel  input  SEL_W  Index of the input to forward.
REQ-009 in_valid  input  1  Marks the current in_bus/sel as a real operand.
REQ-010 stall  input  1  Holds all pipeline stages when high.
REQ-011 flush  input  1  Invalidates all pipeline stages when high.
REQ-012 err_clr  input  1  Clears the sticky sel_err flag.
REQ-013 out  output  LENGTH  Selected data at the last stage.
REQ-014 out_valid  output  1  Valid bit at the last stage.
REQ-015 sel_err  output  1  Sticky flag: an out-of-range sel was captured with in_valid high.

Function
REQ-016 Selection: sel < NUM_IN forwards input[sel]; sel >= NUM_IN forwards input 0.
REQ-017 Latency: a capture at edge N appears on out/out_valid after edge N+STAGES-1, i.e. STAGES cycles after presentation; there is no combinational path from inputs to outputs.
REQ-018 Capture: with stall=0 and flush=0, stage 1 loads {selected data, in_valid} and stage k loads stage k-1 every edge.
REQ-019 Stall: with stall=1 and flush=0, every stage holds its data and valid; inputs are not captured.
REQ-020 Flush: with flush=1, every stage valid clears to 0 and data clears to 0 at the next edge, regardless of stall; flush has priority over stall.
REQ-021 Invalid operands: with in_valid=0, the selected data still propagates; the stage valid is 0.
REQ-022 Error set: sel_err sets at an edge where stall=0, flush=0, in_valid=1 and sel >= NUM_IN.
REQ-023 Error clear: err_clr=1 clears sel_err at the next edge; when set and clear coincide, set wins and sel_err stays 1.
REQ-024 When NUM_IN is a power of two, sel_err is constant 0 and REQ-016's out-of-range case cannot occur.
REQ-025 Stalled or flushed cycles never set sel_err.

Reset
REQ-026 rst=1 at an edge forces all stage data to 0, all stage valids to 0 and sel_err to 0; it overrides stall, flush and err_clr.
REQ-027 After reset: out=0, out_valid=0, sel_err=0 until the first capture propagates.
REQ-028 Reset asserted mid-stream discards all in-flight operands; no valid output follows from pre-reset captures.

Structure
REQ-029 The shared pipeline package holds the NUM_IN/STAGES legal-range constants and the SEL_W derivation function; the block declares no local typedefs.
REQ-030 One sub-module, pipe_stage_reg (LENGTH+1 bits wide, with hold/clear/reset), is instantiated STAGES times in a generate loop.
REQ-031 The selection logic is a single combinational always block in mux_n_pipe; a mux sub-module is not used.

Verification
REQ-032 LENGTH=8, NUM_IN=3, STAGES=1; in_bus={8'h33,8'h22,8'h11}; sel=2, in_valid=1 -> out=8'h33, out_valid=1 one cycle later.
REQ-033 NUM_IN=3; sel=3, in_valid=1 -> out=8'h11 (input 0); sel_err=1 from that edge; err_clr pulse -> sel_err=0; err_clr with illegal sel on the same edge -> sel_err stays 1.
REQ-034 STAGES=3; stream sel=0,1,2 on consecutive cycles; stall high for 2 cycles mid-stream -> output order 11,22,33 preserved, stretched by exactly 2 cycles, no duplicates or drops.
REQ-035 STAGES=3 with 3 valid operands in flight; flush and stall high together -> out_valid=0 and out=0 next cycle, and no valid output for the following 3 cycles.
REQ-036 rst pulsed for one cycle while 2 valid operands are in flight and sel_err=1 -> out=0, out_valid=0, sel_err=0 next cycle; out_valid stays 0 until new captures arrive.
REQ-037 NUM_IN=4, LENGTH=32: sweep sel 0..3 with random data -> out equals input[sel] after STAGES cycles; sel_err is never asserted.
